// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/sub sequencer: FSM state
// encodings, default geometry and the add/sub operation encoding.
package nibble_serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_N     = 4;
  localparam int DEF_WORDS = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Nibble index width: clog2(words), but never narrower than one bit so a
  // single-nibble build still has a legal counter.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Handshake and operand/result bus between the CPU control unit (master)
// and the nibble-serial add/sub sequencer (slave).
// Optional macro ADDSUB_ZERO_FLAG_EN adds the Zero result flag.
interface nibble_serial_addsub_ctrl_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;
  logic         Cout;
  logic         Overflow;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic         Zero;

  modport master (
    output start, sub, A, B,
    input  busy, done, Result, Cout, Overflow, Zero
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, Result, Cout, Overflow, Zero
  );
`else
  modport master (
    output start, sub, A, B,
    input  busy, done, Result, Cout, Overflow
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, Result, Cout, Overflow
  );
`endif

endinterface

// File: rtl/nibble_serial_addsub_ctrl_slice.sv
// N-bit ripple-carry adder slice. Pure addition with an explicit carry in;
// operand inversion for subtraction is the caller's job. Also exposes the
// carry into the MSB so the caller can form signed overflow.
module nibble_addsub_slice
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  // Ripple the carry bit by bit, capturing the carry entering the top bit.
  always_comb begin
    logic cy;
    cy       = cin;
    sum      = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) c_msb_in = cy;
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial wide add/subtract sequencer. Operands are latched on an
// accepted start, then one N-bit nibble per clock (LSB first) goes through
// a single add/sub slice with the carry held in a register between nibbles.
// Handshake: start (sampled in IDLE only), busy (RUN and DONE), done pulse.
// Optional macro ADDSUB_ZERO_FLAG_EN adds a Zero flag on the final result.
module nibble_serial_addsub_ctrl
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WORDS = DEF_WORDS
) (
  input logic                        Clock,
  input logic                        Resetn,
  nibble_serial_addsub_ctrl_if.slave bus
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = idx_width(WORDS);

  state_t state, next_state;

  logic [W-1:0]     a_lat, b_lat;
  logic             sub_lat;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     result_q, result_next;
  logic             cout_q, ovf_q;
  logic             busy, done;
  logic             last;

  logic [N-1:0]     a_nib, b_nib, sum;
  logic             slice_cout, c_msb_in;

`ifdef ADDSUB_ZERO_FLAG_EN
  logic             zero_q;
`endif

  // Select the current nibble, apply the subtract inversion to B, and form
  // the result as it will look once this nibble is written.
  always_comb begin
    a_nib       = a_lat[idx*N +: N];
    b_nib       = b_lat[idx*N +: N] ^ {N{sub_lat}};
    last        = (idx == IDX_W'(WORDS - 1));
    result_next = result_q;
    result_next[idx*N +: N] = sum;
  end

  nibble_addsub_slice #(.N(N)) u_slice (
    .a        (a_nib),
    .b        (b_nib),
    .cin      (carry_q),
    .sum      (sum),
    .cout     (slice_cout),
    .c_msb_in (c_msb_in)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  // Next-state and handshake outputs. DONE always returns to IDLE, so a
  // start seen while in DONE is dropped rather than queued.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) next_state = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last) next_state = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand latch, carry chain register, nibble index and result/flag update.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      a_lat    <= '0;
      b_lat    <= '0;
      sub_lat  <= OP_ADD;
      carry_q  <= 1'b0;
      idx      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_lat   <= bus.A;
            b_lat   <= bus.B;
            sub_lat <= bus.sub;
            // Subtraction is A + ~B + 1: the +1 enters as the first carry.
            carry_q <= (bus.sub == OP_SUB);
            idx     <= '0;
          end
        end
        ST_RUN: begin
          result_q <= result_next;
          carry_q  <= slice_cout;
          if (last) begin
            idx    <= '0;
            cout_q <= slice_cout;
            ovf_q  <= c_msb_in ^ slice_cout;
`ifdef ADDSUB_ZERO_FLAG_EN
            zero_q <= (result_next == '0);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.Result   = result_q;
  assign bus.Cout     = cout_q;
  assign bus.Overflow = ovf_q;
`ifdef ADDSUB_ZERO_FLAG_EN
  assign bus.Zero     = zero_q;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for the nibble-serial add/sub sequencer with a queue
// scoreboard of expected results.
module tb_nibble_serial_addsub_ctrl;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;

  always #5 Clock = ~Clock;

  nibble_serial_addsub_ctrl_if #(.N(N), .WORDS(WORDS)) bus ();

  nibble_serial_addsub_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   passed   = 0;
  int   fails    = 0;
  int   done_cnt = 0;

  always @(posedge Clock) if (bus.done === 1'b1) done_cnt++;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] bb;
    logic [W:0]   full;
    exp_t         e;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
    e.res  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (e.res[W-1] != a[W-1]);
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse at a falling edge; returns one falling edge later.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
    @(negedge Clock);
    bus.A     = a;
    bus.B     = b;
    bus.sub   = s;
    bus.start = 1'b1;
    if (push) sb.push_back(model(a, b, s));
    @(negedge Clock);
    bus.start = 1'b0;
  endtask

  // Called right after start_op; counts edges since acceptance and busy cycles.
  task automatic wait_done(output int edges, output int busy_cycles);
    int k;
    k = 1;
    busy_cycles = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && k < 40) begin
      @(negedge Clock);
      k++;
      if (bus.busy === 1'b1) busy_cycles++;
    end
    edges = k - 1;
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, bus.Result, e.res);
      check({tag, "_cout"}, bus.Cout, e.cout);
      check({tag, "_ovf"}, bus.Overflow, e.ovf);
`ifdef ADDSUB_ZERO_FLAG_EN
      check({tag, "_zero"}, bus.Zero, e.zero);
`endif
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
    int edges, bc;
    start_op(a, b, s, 1'b1);
    wait_done(edges, bc);
    check({tag, "_latency"}, edges, WORDS);
    check({tag, "_busy_cycles"}, bc, WORDS + 1);
    check_result(tag);
    @(negedge Clock);
    check({tag, "_done_drop"}, bus.done, 1'b0);
    check({tag, "_busy_drop"}, bus.busy, 1'b0);
  endtask

  initial begin
    int k, dc0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    // Reset state
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.Result, '0);
    check("rst_cout", bus.Cout, 1'b0);
    check("rst_ovf", bus.Overflow, 1'b0);
`ifdef ADDSUB_ZERO_FLAG_EN
    check("rst_zero", bus.Zero, 1'b0);
`endif
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;

    // Directed arithmetic cases
    run_op(16'h1234, 16'h0FFF, 1'b0, "add_basic");
    check("add_basic_const", bus.Result, 16'h2233);
    repeat (3) @(negedge Clock);
    check("result_hold", bus.Result, 16'h2233);
    run_op(16'hFFFF, 16'h0001, 1'b0, "add_wrap");
    check("add_wrap_const", bus.Result, 16'h0000);
    run_op(16'h0005, 16'h0007, 1'b1, "sub_borrow");
    check("sub_borrow_const", bus.Result, 16'hFFFE);
    run_op(16'h8000, 16'h0001, 1'b1, "sub_ovf");
    check("sub_ovf_const", bus.Overflow, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    check("add_ovf_const", bus.Result, 16'h8000);
    run_op(16'h4321, 16'h4321, 1'b1, "sub_equal");

    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    // start re-pulsed during RUN and during DONE is ignored
    dc0 = done_cnt;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b1);
    @(negedge Clock);
    bus.A     = 16'hAAAA;
    bus.B     = 16'h5555;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    @(negedge Clock);
    bus.start = 1'b0;
    k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(negedge Clock);
      k++;
    end
    check("repulse_done_seen", bus.done, 1'b1);
    bus.A     = 16'h0F0F;
    bus.start = 1'b1;
    check_result("repulse");
    check("repulse_const", bus.Result, 16'h3333);
    @(negedge Clock);
    bus.start = 1'b0;
    check("repulse_idle_after_done", bus.busy, 1'b0);
    repeat (8) @(negedge Clock);
    check("repulse_busy_quiet", bus.busy, 1'b0);
    check("repulse_done_count", done_cnt - dc0, 1);

    // Reset mid-operation at nibble index 2
    dc0 = done_cnt;
    start_op(16'h4321, 16'h1234, 1'b0, 1'b0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_result", bus.Result, '0);
    check("abort_cout", bus.Cout, 1'b0);
    check("abort_ovf", bus.Overflow, 1'b0);
`ifdef ADDSUB_ZERO_FLAG_EN
    check("abort_zero", bus.Zero, 1'b0);
`endif
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (6) @(negedge Clock);
    check("abort_no_done", done_cnt - dc0, 0);
    check("abort_idle", bus.busy, 1'b0);
    run_op(16'hABCD, 16'h1357, 1'b0, "after_abort");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub_ctrl.md
Name: nibble_serial_addsub_ctrl

Overview:
Sequencer that performs wide add/subtract on a single 4-bit add/sub slice, one nibble per clock, LSB nibble first.
- Holds a carry/borrow register between nibbles.
- Latches the operands and shifts the result in.
- Handshake: start / busy / done, toward the CPU control unit.
- Lets the 4-bit microprocessor execute 16-bit ADD/SUB with no 16-bit adder.

Parameters:
N, 4, slice width in bits
WORDS, 4, nibbles per operand (operand width W = N*WORDS)

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
start  in  1  request operation; sampled only in IDLE
sub  in  1  0 = A+B, 1 = A-B; latched with start
A  in  W  operand A; latched with start
B  in  W  operand B; latched with start
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse, Result/flags valid
Result  out  W  sum/difference; held until next accepted start
Cout  out  1  final carry out (sub: 1 = no borrow)
Overflow  out  1  signed overflow of the W-bit operation

Behaviour:
- Reset (async, Resetn=0): state=IDLE; busy=0, done=0, Result=0, Cout=0, Overflow=0, nibble index=0, carry reg=0. Reset mid-operation aborts immediately; no done is produced.
- States:
  - IDLE: busy=0. start=1 at an edge → latch A, B, sub; carry reg←sub; index←0; go to RUN.
  - RUN: each edge, the slice computes nibble[index]:
    - inputs: A nibble, B nibble XOR {N{sub}}, cin = carry reg
    - actions: Result nibble[index] ← sum; carry reg ← slice cout; index++
    - on the edge processing index=WORDS-1: Cout ← slice cout; Overflow ← (carry into slice MSB) XOR (slice cout); go to DONE.
  - DONE: done=1, busy=1 for exactly one cycle; next edge → IDLE.
- Latency: done is high in the cycle beginning WORDS edges after the edge that sampled start (WORDS+1 cycles from start acceptance to return to IDLE).
- start while busy (RUN or DONE) is ignored and not queued. A start asserted in IDLE on the same edge DONE→IDLE occurs does not apply: DONE takes precedence.
- Operand or sub changes after acceptance have no effect (latched copies are used).
- Result nibbles not yet written during RUN hold their previous contents. Result is valid only from done onward.
- Arithmetic: modulo 2^W.
  - sub=1 computes A + ~B + 1.
  - Cout=1 for sub means A >= B unsigned.
- Index counter width = clog2(WORDS), minimum 1. WORDS=1 degenerates to a single RUN cycle.

Optional Feature:
Macro ADDSUB_ZERO_FLAG_EN.
- Defined: adds output port Zero (1 bit, reset 0). Zero is computed from the final Result and updated on the same edge as Cout. Zero=1 iff Result==0.
- Undefined: no Zero port, and no zero-detect logic is generated.

Decomposition:
- Shared package/header: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2), default N/WORDS constants, and the op encoding (OP_ADD=0, OP_SUB=1).
- One sub-module: nibble_addsub_slice.
  - N-bit ripple full-adder chain with an explicit cin, separate from the sub inversion.
  - Outputs sum, cout and c_msb_in (carry into the MSB) for the overflow calculation.
  - The controller owns the B inversion and the carry register.

Test Plan:
- A=0x1234, B=0x0FFF, sub=0, start one cycle → done 4 cycles later; Result=0x2233, Cout=0, Overflow=0; busy high for 5 cycles.
- A=0xFFFF, B=0x0001, sub=0 → Result=0x0000, Cout=1, Overflow=0 (Zero=1 when ADDSUB_ZERO_FLAG_EN is defined).
- A=0x0005, B=0x0007, sub=1 → Result=0xFFFE, Cout=0 (borrow), Overflow=0; A=0x8000, B=0x0001, sub=1 → Result=0x7FFF, Overflow=1, Cout=1.
- A=0x7FFF, B=0x0001, sub=0 → Result=0x8000, Overflow=1, Cout=0.
- Start accepted, then start re-pulsed with new A/B during RUN and again during DONE → exactly one done; Result reflects the first operands only.
- Resetn pulsed low for 1 cycle at RUN index=2 → all outputs 0 immediately, state IDLE, no done; a following start completes normally.
